counter_register_bank: RTL and testbench

//  Parametrised bank of NREGS loadable up-counters (74HC161-style slices) with an addressed store port and an addressed read port.

---
 rtl/counter_cell.sv | 40 ++++
 rtl/counter_register_bank.sv | 84 ++++++++
 tb/tb_counter_register_bank.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_cell.sv
// Purpose: one loadable up-counter slice with 74HC161-style carry-enable cascade.
// Latency: load and count take effect on the next rising CLK; CO is combinational.
// Backpressure: none; LOAD has priority over counting, RST over both.
//
// Ports:
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   LOAD, DATAIN    parallel load (active-high) and load data
//   ENP, ENT        count enables; both high to increment
//   Q, CO           current value and ripple carry out
module counter_cell #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else if (LOAD) begin
      r_q <= DATAIN;
    end else if (ENP && ENT) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign Q  = r_q;
  // Carry is taken from the present value, so a load into this slice in the
  // same cycle does not suppress the increment of the next slice.
  assign CO = ENT & ENP & (&r_q);

endmodule

// File: rtl/counter_register_bank.sv
// Purpose: bank of NREGS loadable counters with addressed store and read ports, optional carry chaining.
// Latency: store/count visible the cycle after the edge; LOADDATA and CO are combinational.
// Backpressure: none; every strobe is accepted, out-of-range addresses are ignored.
//
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   nST, ST_ADDR        active-low store strobe and target register
//   STOREDATA           store data
//   INC_EN              per-register count enable
//   nOUT, OUT_ADDR      active-low read enable and source register
//   LOADDATA            read data: 0 or 'z when disabled/out of range (TRISTATE)
//   COUNTER, CO         all register values (reg i at [i*WIDTH +: WIDTH]), per-register carry
module counter_register_bank #(
  parameter  int WIDTH    = 4,
  parameter  int NREGS    = 2,
  parameter  int CHAIN    = 0,
  parameter  int TRISTATE = 0,
  localparam int AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   nST,
  input  logic [AW-1:0]          ST_ADDR,
  input  logic [WIDTH-1:0]       STOREDATA,
  input  logic [NREGS-1:0]       INC_EN,
  input  logic                   nOUT,
  input  logic [AW-1:0]          OUT_ADDR,
  output logic [WIDTH-1:0]       LOADDATA,
  output logic [NREGS*WIDTH-1:0] COUNTER,
  output logic [NREGS-1:0]       CO
);

  logic [NREGS-1:0] w_ten;
  logic [NREGS-1:0] w_load;
  logic [NREGS-1:0] w_co;
  logic [WIDTH-1:0] w_q [NREGS];
  logic [WIDTH-1:0] w_rd;
  logic             w_rd_vld;

  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    // In chained mode each slice only counts when the one below wraps.
    if (g == 0 || CHAIN == 0) begin : g_ten_free
      assign w_ten[g] = 1'b1;
    end else begin : g_ten_chain
      assign w_ten[g] = w_co[g-1];
    end

    assign w_load[g] = ~nST && (ST_ADDR == AW'(g));

    counter_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK    (CLK),
      .RST    (RST),
      .LOAD   (w_load[g]),
      .DATAIN (STOREDATA),
      .ENP    (INC_EN[g]),
      .ENT    (w_ten[g]),
      .Q      (w_q[g]),
      .CO     (w_co[g])
    );

    assign COUNTER[g*WIDTH +: WIDTH] = w_q[g];
  end

  assign CO = w_co;

  // Decode by match so an address beyond NREGS simply finds no register.
  always_comb begin
    w_rd     = '0;
    w_rd_vld = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (OUT_ADDR == AW'(i)) begin
        w_rd     = w_q[i];
        w_rd_vld = ~nOUT;
      end
    end
  end

  if (TRISTATE != 0) begin : g_rd_tri
    assign LOADDATA = w_rd_vld ? w_rd : {WIDTH{1'bz}};
  end else begin : g_rd_zero
    assign LOADDATA = w_rd_vld ? w_rd : '0;
  end

endmodule

// File: tb/tb_counter_register_bank.sv
module tb_counter_register_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // d0: NREGS=2 independent, TRISTATE=0; d1: NREGS=2 chained; d2: NREGS=3 independent, TRISTATE=1
  logic       st_n0, st_n1, st_n2;
  logic [0:0] st_a0, st_a1;
  logic [1:0] st_a2;
  logic [3:0] sd0, sd1, sd2;
  logic [1:0] inc0, inc1;
  logic [2:0] inc2;
  logic       out_n0, out_n1, out_n2;
  logic [0:0] out_a0, out_a1;
  logic [1:0] out_a2;
  logic [3:0] ld0, ld1, ld2;
  logic [7:0] cnt0, cnt1;
  logic [11:0] cnt2;
  logic [1:0] co0, co1;
  logic [2:0] co2;

  counter_register_bank #(.WIDTH(4), .NREGS(2), .CHAIN(0), .TRISTATE(0)) u_d0 (
    .CLK(clk), .RST(rst), .nST(st_n0), .ST_ADDR(st_a0), .STOREDATA(sd0), .INC_EN(inc0),
    .nOUT(out_n0), .OUT_ADDR(out_a0), .LOADDATA(ld0), .COUNTER(cnt0), .CO(co0));

  counter_register_bank #(.WIDTH(4), .NREGS(2), .CHAIN(1), .TRISTATE(0)) u_d1 (
    .CLK(clk), .RST(rst), .nST(st_n1), .ST_ADDR(st_a1), .STOREDATA(sd1), .INC_EN(inc1),
    .nOUT(out_n1), .OUT_ADDR(out_a1), .LOADDATA(ld1), .COUNTER(cnt1), .CO(co1));

  counter_register_bank #(.WIDTH(4), .NREGS(3), .CHAIN(0), .TRISTATE(1)) u_d2 (
    .CLK(clk), .RST(rst), .nST(st_n2), .ST_ADDR(st_a2), .STOREDATA(sd2), .INC_EN(inc2),
    .nOUT(out_n2), .OUT_ADDR(out_a2), .LOADDATA(ld2), .COUNTER(cnt2), .CO(co2));

  typedef struct packed {
    logic [11:0] c0;
    logic [11:0] c1;
    logic [11:0] c2;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] m [3];
  bit          m_vld = 1'b0;
  int          n_run = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one bank: returns the register image after the edge.
  function automatic logic [11:0] mdl_next(input logic [11:0] cur, input int n, input bit chain,
                                           input logic r, input logic st_n, input int st_a,
                                           input logic [3:0] sd, input logic [2:0] inc);
    logic [11:0] nx;
    logic [3:0]  v;
    bit          ten, c;
    nx  = cur;
    ten = 1'b1;
    if (r) return 12'h000;
    for (int i = 0; i < n; i++) begin
      v = cur[i*4 +: 4];
      c = ten && inc[i] && (v == 4'hF);
      if (!st_n && st_a == i) nx[i*4 +: 4] = sd;
      else if (ten && inc[i]) nx[i*4 +: 4] = v + 4'h1;
      ten = chain ? c : 1'b1;
    end
    return nx;
  endfunction

  function automatic logic [2:0] mdl_co(input logic [11:0] cur, input int n, input bit chain,
                                        input logic [2:0] inc);
    logic [2:0] co;
    bit         ten;
    co  = 3'b000;
    ten = 1'b1;
    for (int i = 0; i < n; i++) begin
      co[i] = ten && inc[i] && (cur[i*4 +: 4] == 4'hF);
      ten = chain ? co[i] : 1'b1;
    end
    return co;
  endfunction

  function automatic logic [3:0] mdl_rd(input logic [11:0] cur, input int n, input bit tri_en,
                                        input logic out_n, input int addr);
    if (!out_n && addr < n) return cur[addr*4 +: 4];
    return tri_en ? 4'bzzzz : 4'h0;
  endfunction

  // One clock: check combinational outputs against the model, queue the
  // expected register images, then compare them after the edge.
  task automatic tick();
    exp_t e, got;
    #1;
    if (m_vld) begin
      chk("co0", {10'b0, co0}, {9'b0, mdl_co(m[0], 2, 1'b0, {1'b0, inc0})});
      chk("co1", {10'b0, co1}, {9'b0, mdl_co(m[1], 2, 1'b1, {1'b0, inc1})});
      chk("co2", {9'b0, co2},  {9'b0, mdl_co(m[2], 3, 1'b0, inc2)});
      chk("ld0", {8'b0, ld0}, {8'b0, mdl_rd(m[0], 2, 1'b0, out_n0, int'(out_a0))});
      chk("ld1", {8'b0, ld1}, {8'b0, mdl_rd(m[1], 2, 1'b0, out_n1, int'(out_a1))});
      chk("ld2", {8'b0, ld2}, {8'b0, mdl_rd(m[2], 3, 1'b1, out_n2, int'(out_a2))});
    end
    e.c0 = mdl_next(m[0], 2, 1'b0, rst, st_n0, int'(st_a0), sd0, {1'b0, inc0});
    e.c1 = mdl_next(m[1], 2, 1'b1, rst, st_n1, int'(st_a1), sd1, {1'b0, inc1});
    e.c2 = mdl_next(m[2], 3, 1'b0, rst, st_n2, int'(st_a2), sd2, inc2);
    sb.push_back(e);
    m[0] = e.c0;
    m[1] = e.c1;
    m[2] = e.c2;
    if (rst) m_vld = 1'b1;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("cnt0", {4'b0, cnt0}, got.c0);
    chk("cnt1", {4'b0, cnt1}, got.c1);
    chk("cnt2", cnt2, got.c2);
  endtask

  task automatic idle();
    rst = 1'b0;
    st_n0 = 1'b1; st_n1 = 1'b1; st_n2 = 1'b1;
    st_a0 = 1'b0; st_a1 = 1'b0; st_a2 = 2'd0;
    sd0 = 4'h0; sd1 = 4'h0; sd2 = 4'h0;
    inc0 = 2'b00; inc1 = 2'b00; inc2 = 3'b000;
    out_n0 = 1'b1; out_n1 = 1'b1; out_n2 = 1'b1;
    out_a0 = 1'b0; out_a1 = 1'b0; out_a2 = 2'd0;
  endtask

  initial begin
    m[0] = '0; m[1] = '0; m[2] = '0;
    idle();
    // reset and read of an all-zero bank
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cnt0", {4'b0, cnt0}, 12'h000);
    chk("rst_co0", {10'b0, co0}, 12'h000);
    out_n0 = 1'b0; out_a0 = 1'b1;
    out_n1 = 1'b0; out_a1 = 1'b1;
    out_n2 = 1'b0; out_a2 = 2'd1;
    tick();

    // store to reg1 with same-cycle read of reg1 (old value)
    st_n0 = 1'b0; st_a0 = 1'b1; sd0 = 4'hA;
    tick();
    st_n0 = 1'b1;
    chk("st_reg1", {8'b0, cnt0[7:4]}, 12'h00A);
    chk("st_reg0", {8'b0, cnt0[3:0]}, 12'h000);
    tick();

    // independent count through the wrap
    st_n0 = 1'b0; st_a0 = 1'b0; sd0 = 4'hE;
    tick();
    st_n0 = 1'b1; inc0 = 2'b01;
    repeat (3) tick();
    inc0 = 2'b00;
    chk("wrap_cnt0", {4'b0, cnt0}, 12'h0A1);

    // chained: 0F -> 10, then 0F with store on reg0 -> 13
    st_n1 = 1'b0; st_a1 = 1'b0; sd1 = 4'hF;
    tick();
    st_n1 = 1'b1; inc1 = 2'b11;
    tick();
    chk("chain_inc", {4'b0, cnt1}, 12'h010);
    inc1 = 2'b00; st_n1 = 1'b0; st_a1 = 1'b0; sd1 = 4'hF;
    tick();
    st_a1 = 1'b1; sd1 = 4'h0;
    tick();
    st_a1 = 1'b0; sd1 = 4'h3; inc1 = 2'b11;
    tick();
    chk("chain_store", {4'b0, cnt1}, 12'h013);
    st_n1 = 1'b1; inc1 = 2'b00;

    // disabled and out-of-range reads, out-of-range store
    out_n0 = 1'b1; out_n2 = 1'b1;
    tick();
    out_n2 = 1'b0; out_a2 = 2'd3;
    st_n2 = 1'b0; st_a2 = 2'd3; sd2 = 4'h5;
    tick();
    chk("oor_store", cnt2, 12'h000);
    st_a2 = 2'd2; out_a2 = 2'd2; sd2 = 4'h7;
    tick();
    st_n2 = 1'b1;
    tick();

    // reset while counting and storing
    inc0 = 2'b11; inc1 = 2'b11; inc2 = 3'b111;
    st_n0 = 1'b0; st_n1 = 1'b0; st_n2 = 1'b0; sd0 = 4'h9; sd1 = 4'h9; sd2 = 4'h9;
    rst = 1'b1;
    tick();
    chk("rst_mid", cnt2, 12'h000);
    rst = 1'b0; st_n0 = 1'b1; st_n1 = 1'b1; st_n2 = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 60; i++) begin
      rst    = ($urandom_range(0, 29) == 0);
      st_n0  = 1'($urandom_range(0, 1)); st_n1 = 1'($urandom_range(0, 1)); st_n2 = 1'($urandom_range(0, 1));
      st_a0  = 1'($urandom_range(0, 1)); st_a1 = 1'($urandom_range(0, 1)); st_a2 = 2'($urandom_range(0, 3));
      sd0    = 4'($urandom_range(0, 15)); sd1 = 4'($urandom_range(0, 15)); sd2 = 4'($urandom_range(0, 15));
      inc0   = 2'($urandom_range(0, 3)); inc1 = 2'($urandom_range(0, 3)); inc2 = 3'($urandom_range(0, 7));
      out_n0 = 1'($urandom_range(0, 1)); out_n1 = 1'($urandom_range(0, 1)); out_n2 = 1'($urandom_range(0, 1));
      out_a0 = 1'($urandom_range(0, 1)); out_a1 = 1'($urandom_range(0, 1)); out_a2 = 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
